// File: rtl/llsc_mem_ctrl.sv
// llsc_mem_ctrl: MEM-stage LL/SC controller; runs the bus access, decides SC success, drives the LL-bit write port.
// Define LLSC_ADDR_CHECK_EN to add link-address tracking with external-store snooping.
module llsc_mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              op_valid,
  input  logic              op_ll,
  input  logic              op_sc,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] sc_wdata,
  input  logic              ll_bit,
  output logic              llbit_we,
  output logic              llbit_wdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              stall_o,
  output logic              addr_err,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  input  logic              snoop_valid,
  input  logic [ADDR_W-1:0] snoop_addr
);

  typedef enum logic [1:0] {
    IDLE,
    LL_BUS,
    SC_BUS,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] busAddr_q, busAddr_d;
  logic [DATA_W-1:0] busWdata_q, busWdata_d;
  logic [DATA_W-1:0] resData_q, resData_d;

  logic wordAligned;
  logic isLl;
  logic isSc;
  logic scOk;

  assign wordAligned = (addr[1:0] == 2'b00);
  assign isLl        = op_valid & op_ll;
  assign isSc        = op_valid & op_sc & ~op_ll;

`ifdef LLSC_ADDR_CHECK_EN
  logic [ADDR_W-1:2] linkAddr_q, linkAddr_d;
  logic              linkValid_q, linkValid_d;
  logic              snoopHitsLink;
  logic              snoopHitsSc;
  logic              unusedSnoopLo;

  assign snoopHitsLink = snoop_valid & (snoop_addr[ADDR_W-1:2] == linkAddr_q);
  assign snoopHitsSc   = snoop_valid & (snoop_addr[ADDR_W-1:2] == addr[ADDR_W-1:2]);
  assign unusedSnoopLo = ^snoop_addr[1:0];
  assign scOk = ll_bit & linkValid_q & (addr[ADDR_W-1:2] == linkAddr_q) & ~snoopHitsSc;

  // An LL completion arms the link; SC completion, flush or a matching external store disarm it.
  always_comb begin
    linkAddr_d  = linkAddr_q;
    linkValid_d = linkValid_q;
    if (snoopHitsLink) begin
      linkValid_d = 1'b0;
    end
    if (state_q == LL_BUS && bus_ack) begin
      linkAddr_d  = busAddr_q[ADDR_W-1:2];
      linkValid_d = 1'b1;
    end
    if (state_q == SC_BUS && bus_ack) begin
      linkValid_d = 1'b0;
    end
    if (flush) begin
      linkValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      linkAddr_q  <= '0;
      linkValid_q <= 1'b0;
    end else begin
      linkAddr_q  <= linkAddr_d;
      linkValid_q <= linkValid_d;
    end
  end
`else
  logic unusedSnoop;

  assign unusedSnoop = ^{snoop_valid, snoop_addr};
  assign scOk        = ll_bit;
`endif

  // Next-state and per-cycle control; flush overrides whatever the current state decided.
  always_comb begin
    state_d     = state_q;
    busAddr_d   = busAddr_q;
    busWdata_d  = busWdata_q;
    resData_d   = resData_q;
    llbit_we    = 1'b0;
    llbit_wdata = 1'b0;
    stall_o     = 1'b0;
    addr_err    = 1'b0;
    res_valid   = 1'b0;

    case (state_q)
      IDLE: begin
        if (isLl || isSc) begin
          if (!wordAligned) begin
            addr_err = 1'b1;
          end else if (isLl) begin
            stall_o   = 1'b1;
            busAddr_d = {addr[ADDR_W-1:2], 2'b00};
            state_d   = LL_BUS;
          end else if (scOk) begin
            stall_o    = 1'b1;
            busAddr_d  = {addr[ADDR_W-1:2], 2'b00};
            busWdata_d = sc_wdata;
            state_d    = SC_BUS;
          end else begin
            stall_o   = 1'b1;
            resData_d = '0;
            state_d   = DONE;
          end
        end
      end
      LL_BUS: begin
        stall_o = 1'b1;
        if (bus_ack) begin
          llbit_we    = 1'b1;
          llbit_wdata = 1'b1;
          resData_d   = bus_rdata;
          state_d     = DONE;
        end
      end
      SC_BUS: begin
        stall_o = 1'b1;
        if (bus_ack) begin
          llbit_we    = 1'b1;
          llbit_wdata = 1'b0;
          resData_d   = {{(DATA_W-1){1'b0}}, 1'b1};
          state_d     = DONE;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (flush) begin
      state_d     = IDLE;
      busAddr_d   = busAddr_q;
      busWdata_d  = busWdata_q;
      resData_d   = resData_q;
      llbit_we    = 1'b0;
      llbit_wdata = 1'b0;
      stall_o     = 1'b0;
      addr_err    = 1'b0;
      res_valid   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      busAddr_q  <= '0;
      busWdata_q <= '0;
      resData_q  <= '0;
    end else begin
      state_q    <= state_d;
      busAddr_q  <= busAddr_d;
      busWdata_q <= busWdata_d;
      resData_q  <= resData_d;
    end
  end

  assign bus_req   = (state_q == LL_BUS) || (state_q == SC_BUS);
  assign bus_we    = (state_q == SC_BUS);
  assign bus_addr  = busAddr_q;
  assign bus_wdata = busWdata_q;
  assign res_data  = resData_q;

endmodule

// File: tb/tb_llsc_mem_ctrl.sv
// tb_llsc_mem_ctrl: directed cycle table plus randomized LL/SC transactions against a transaction-level model.
// The link/snoop expectations follow LLSC_ADDR_CHECK_EN when it is defined.
module tb_llsc_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        op_valid;
  logic        op_ll;
  logic        op_sc;
  logic [31:0] addr;
  logic [31:0] sc_wdata;
  logic        ll_bit;
  logic        llbit_we;
  logic        llbit_wdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        stall_o;
  logic        addr_err;
  logic        res_valid;
  logic [31:0] res_data;
  logic        snoop_valid;
  logic [31:0] snoop_addr;

  int checks;
  int errors;

  llsc_mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .op_valid(op_valid), .op_ll(op_ll), .op_sc(op_sc),
    .addr(addr), .sc_wdata(sc_wdata), .ll_bit(ll_bit),
    .llbit_we(llbit_we), .llbit_wdata(llbit_wdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .stall_o(stall_o), .addr_err(addr_err),
    .res_valid(res_valid), .res_data(res_data),
    .snoop_valid(snoop_valid), .snoop_addr(snoop_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One directed cycle: inputs for that cycle and the outputs expected in it.
  // ctl packs {llbit_we, llbit_wdata, bus_req, bus_we, stall_o, addr_err, res_valid}.
  typedef struct {
    string       name;
    logic        fl, ov, ol, os;
    logic [31:0] a, wd;
    logic        lb, ak;
    logic [31:0] rd;
    logic [6:0]  ctl;
    logic [31:0] eBusAddr, eBusWdata, eResData;
  } vec_t;

  vec_t vecs[$];

  // Transaction-level model state: LL register contents, link, and backing memory.
  logic        modelLl;
  logic        linkValid;
  logic [29:0] linkWord;
  logic [31:0] mem [logic [29:0]];

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic addVec(input string nm, input logic fl, input logic ov, input logic ol, input logic os,
                        input logic [31:0] a, input logic [31:0] wd, input logic lb, input logic ak,
                        input logic [31:0] rd, input logic [6:0] ctl,
                        input logic [31:0] ba, input logic [31:0] bw, input logic [31:0] rs);
    vec_t v;
    v.name = nm; v.fl = fl; v.ov = ov; v.ol = ol; v.os = os;
    v.a = a; v.wd = wd; v.lb = lb; v.ak = ak; v.rd = rd; v.ctl = ctl;
    v.eBusAddr = ba; v.eBusWdata = bw; v.eResData = rs;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    flush = v.fl; op_valid = v.ov; op_ll = v.ol; op_sc = v.os;
    addr = v.a; sc_wdata = v.wd; ll_bit = v.lb; bus_ack = v.ak; bus_rdata = v.rd;
    snoop_valid = 1'b0; snoop_addr = '0;
    #1;
    checkOutput({v.name, ".ctl"},
                {25'd0, llbit_we, llbit_wdata, bus_req, bus_we, stall_o, addr_err, res_valid},
                {25'd0, v.ctl});
    checkOutput({v.name, ".bus_addr"}, bus_addr, v.eBusAddr);
    checkOutput({v.name, ".bus_wdata"}, bus_wdata, v.eBusWdata);
    checkOutput({v.name, ".res_data"}, res_data, v.eResData);
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; op_valid = 1'b0; op_ll = 1'b0; op_sc = 1'b0;
    addr = '0; sc_wdata = '0; ll_bit = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    snoop_valid = 1'b0; snoop_addr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    modelLl = 1'b0;
    linkValid = 1'b0;
    linkWord = '0;
  endtask

  function automatic logic [31:0] memRead(input logic [29:0] w);
    if (mem.exists(w)) return mem[w];
    return {w[15:0], 16'hA5C3} ^ 32'h3C00_0000;
  endfunction

  // Idle cycle with an optional external store; nothing may be in flight.
  task automatic idleCycle(input logic sv, input logic [31:0] sa);
    @(negedge clk);
    op_valid = 1'b0; op_ll = 1'b0; op_sc = 1'b0; bus_ack = 1'b0; ll_bit = modelLl;
    snoop_valid = sv; snoop_addr = sa;
`ifdef LLSC_ADDR_CHECK_EN
    if (sv && sa[31:2] == linkWord) linkValid = 1'b0;
`endif
    #1;
    checkOutput("idle.quiet", {29'd0, stall_o, bus_req, res_valid}, 32'd0);
  endtask

  // Runs one LL (isSc=0) or SC (isSc=1), acting as bus slave with ackDelay wait cycles.
  task automatic runTxn(input logic isSc, input logic [31:0] a, input logic [31:0] d,
                        input int ackDelay, input logic sn, input logic [31:0] sa);
    logic [29:0] word;
    logic        ok;
    logic [31:0] expRes;
    int          expLat;
    int          expWe;
    logic        expWd;
    int          expWrites;
    int          lat;
    int          waitCnt;
    int          weCount;
    logic        weVal;
    int          writes;
    logic [31:0] wAddr;
    logic [31:0] wData;
    logic [31:0] gotRes;

    word = a[31:2];
    @(negedge clk);
    flush = 1'b0; op_valid = 1'b1; op_ll = ~isSc; op_sc = isSc;
    addr = a; sc_wdata = d; ll_bit = modelLl; bus_ack = 1'b0; bus_rdata = $urandom;
    snoop_valid = sn; snoop_addr = sa;

    if (a[1:0] != 2'b00) begin
      #1;
      checkOutput("misaligned.addr_err", {31'd0, addr_err}, 32'd1);
      checkOutput("misaligned.stall", {31'd0, stall_o}, 32'd0);
      checkOutput("misaligned.bus_req", {31'd0, bus_req}, 32'd0);
      @(negedge clk);
      op_valid = 1'b0; snoop_valid = 1'b0;
      return;
    end

    if (!isSc) begin
      expRes = memRead(word); expLat = 2 + ackDelay; expWe = 1; expWd = 1'b1; expWrites = 0;
    end else begin
`ifdef LLSC_ADDR_CHECK_EN
      ok = modelLl && linkValid && (word == linkWord) && !(sn && sa[31:2] == word);
`else
      ok = modelLl;
`endif
      if (ok) begin
        expRes = 32'd1; expLat = 2 + ackDelay; expWe = 1; expWd = 1'b0; expWrites = 1;
      end else begin
        expRes = 32'd0; expLat = 1; expWe = 0; expWd = 1'b0; expWrites = 0;
      end
    end

    lat = -1; waitCnt = 0; weCount = 0; weVal = 1'b0; writes = 0;
    wAddr = '0; wData = '0; gotRes = '0;
    for (int c = 0; c < 40 && lat < 0; c++) begin
      if (c > 0) begin
        @(negedge clk);
        snoop_valid = 1'b0;
        bus_ack = 1'b0;
        bus_rdata = $urandom;
        if (bus_req) begin
          if (waitCnt == ackDelay) begin
            bus_ack = 1'b1;
            bus_rdata = memRead(bus_addr[31:2]);
          end else begin
            waitCnt++;
          end
        end
      end
      #1;
      if (llbit_we) begin
        weCount++;
        weVal = llbit_wdata;
      end
      if (bus_ack && bus_req && bus_we) begin
        writes++;
        wAddr = bus_addr;
        wData = bus_wdata;
      end
      if (res_valid) begin
        lat = c;
        gotRes = res_data;
      end
    end
    @(negedge clk);
    op_valid = 1'b0; op_ll = 1'b0; op_sc = 1'b0; bus_ack = 1'b0; snoop_valid = 1'b0;

    checkOutput(isSc ? "sc.latency" : "ll.latency", lat, expLat);
    checkOutput(isSc ? "sc.res_data" : "ll.res_data", gotRes, expRes);
    checkOutput(isSc ? "sc.llbit_we_count" : "ll.llbit_we_count", weCount, expWe);
    if (expWe != 0) checkOutput("llbit_wdata", {31'd0, weVal}, {31'd0, expWd});
    checkOutput("bus_write_count", writes, expWrites);
    if (expWrites != 0) begin
      checkOutput("sc.bus_addr", wAddr, {word, 2'b00});
      checkOutput("sc.bus_wdata", wData, d);
    end

`ifdef LLSC_ADDR_CHECK_EN
    if (isSc && sn && sa[31:2] == linkWord) linkValid = 1'b0;
`endif
    if (!isSc) begin
      modelLl = 1'b1; linkValid = 1'b1; linkWord = word;
    end else if (ok) begin
      modelLl = 1'b0; linkValid = 1'b0; mem[word] = d;
    end
  endtask

  initial begin
    int          k;
    logic [31:0] a;
    logic [31:0] lastLl;
    logic        sn;
    logic [31:0] sa;

    checks = 0;
    errors = 0;
    mem.delete();

    //       name            fl ov ol os addr          wdata  lb ak rdata          ctl          busAddr       busWdata res
    addVec("idle",          0, 0, 0, 0, 32'h0,        32'h0, 0, 0, 32'h0,        7'b0000000, 32'h0,        32'h0, 32'h0);
    addVec("llAccept",      0, 1, 1, 0, 32'h100,      32'h0, 0, 0, 32'h0,        7'b0000100, 32'h0,        32'h0, 32'h0);
    addVec("llAck",         0, 1, 1, 0, 32'h100,      32'h0, 0, 1, 32'hDEAD,     7'b1110100, 32'h100,      32'h0, 32'h0);
    addVec("llDone",        0, 1, 1, 0, 32'h100,      32'h0, 1, 0, 32'h0,        7'b0000001, 32'h100,      32'h0, 32'hDEAD);
    addVec("scAccept",      0, 1, 0, 1, 32'h100,      32'h5, 1, 0, 32'h0,        7'b0000100, 32'h100,      32'h0, 32'hDEAD);
    addVec("scWait",        0, 1, 0, 1, 32'h100,      32'h5, 1, 0, 32'h0,        7'b0011100, 32'h100,      32'h5, 32'hDEAD);
    addVec("scAck",         0, 1, 0, 1, 32'h100,      32'h5, 1, 1, 32'h0,        7'b1011100, 32'h100,      32'h5, 32'hDEAD);
    addVec("scDone",        0, 1, 0, 1, 32'h100,      32'h5, 0, 0, 32'h0,        7'b0000001, 32'h100,      32'h5, 32'h1);
    addVec("scFail",        0, 1, 0, 1, 32'h104,      32'h7, 0, 0, 32'h0,        7'b0000100, 32'h100,      32'h5, 32'h1);
    addVec("scFailDone",    0, 1, 0, 1, 32'h104,      32'h7, 0, 0, 32'h0,        7'b0000001, 32'h100,      32'h5, 32'h0);
    addVec("scMisaligned",  0, 1, 0, 1, 32'h101,      32'h9, 1, 0, 32'h0,        7'b0000010, 32'h100,      32'h5, 32'h0);
    addVec("llMisaligned",  0, 1, 1, 0, 32'h202,      32'h0, 0, 0, 32'h0,        7'b0000010, 32'h100,      32'h5, 32'h0);
    addVec("llAccept2",     0, 1, 1, 0, 32'h200,      32'h0, 0, 0, 32'h0,        7'b0000100, 32'h100,      32'h5, 32'h0);
    addVec("flushAck",      1, 1, 1, 0, 32'h200,      32'h0, 0, 1, 32'h1234,     7'b0010000, 32'h200,      32'h5, 32'h0);
    addVec("lateAck",       0, 0, 0, 0, 32'h0,        32'h0, 0, 1, 32'h5555,     7'b0000000, 32'h200,      32'h5, 32'h0);
    addVec("llAccept3",     0, 1, 1, 0, 32'h300,      32'h0, 0, 0, 32'h0,        7'b0000100, 32'h200,      32'h5, 32'h0);
    addVec("llAck3",        0, 1, 1, 0, 32'h300,      32'h0, 0, 1, 32'hCAFE,     7'b1110100, 32'h300,      32'h5, 32'h0);
    addVec("flushDone",     1, 1, 1, 0, 32'h300,      32'h0, 1, 0, 32'h0,        7'b0000000, 32'h300,      32'h5, 32'hCAFE);
    addVec("idleAfter",     0, 0, 0, 0, 32'h0,        32'h0, 1, 0, 32'h0,        7'b0000000, 32'h300,      32'h5, 32'hCAFE);
    addVec("flushIdleLl",   1, 1, 1, 0, 32'h500,      32'h0, 1, 0, 32'h0,        7'b0000000, 32'h300,      32'h5, 32'hCAFE);
    addVec("afterFlush",    0, 0, 0, 0, 32'h0,        32'h0, 1, 0, 32'h0,        7'b0000000, 32'h300,      32'h5, 32'hCAFE);
    addVec("bothAccept",    0, 1, 1, 1, 32'h400,      32'h9, 1, 0, 32'h0,        7'b0000100, 32'h300,      32'h5, 32'hCAFE);
    addVec("bothAck",       0, 1, 1, 1, 32'h400,      32'h9, 1, 1, 32'h77,       7'b1110100, 32'h400,      32'h5, 32'hCAFE);
    addVec("bothDone",      0, 1, 1, 1, 32'h400,      32'h9, 1, 0, 32'h0,        7'b0000001, 32'h400,      32'h5, 32'h77);
    addVec("idleEnd",       0, 0, 0, 0, 32'h0,        32'h0, 1, 0, 32'h0,        7'b0000000, 32'h400,      32'h5, 32'h77);

    resetDut();
    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

    // LL, external store to the same word, then SC to that word.
    resetDut();
    runTxn(1'b0, 32'h100, 32'h0, 1, 1'b0, 32'h0);
    idleCycle(1'b1, 32'h102);
    runTxn(1'b1, 32'h100, 32'h5, 0, 1'b0, 32'h0);
    // SC with no prior LL, then LL/SC pair with a long bus wait.
    runTxn(1'b1, 32'h104, 32'h11, 0, 1'b0, 32'h0);
    runTxn(1'b0, 32'h104, 32'h0, 3, 1'b0, 32'h0);
    runTxn(1'b1, 32'h104, 32'h22, 4, 1'b0, 32'h0);
    runTxn(1'b0, 32'h104, 32'h0, 0, 1'b0, 32'h0);

    resetDut();
    lastLl = 32'h100;
    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 9);
      a = 32'h100 + ($urandom_range(0, 3) << 2);
      if ($urandom_range(0, 7) == 0) modelLl = 1'b0;
      if (k < 4) begin
        runTxn(1'b0, a, 32'h0, $urandom_range(0, 3), 1'b0, 32'h0);
        lastLl = a;
      end else if (k < 8) begin
        if ($urandom_range(0, 9) < 7) a = lastLl;
        sn = ($urandom_range(0, 3) == 0);
        sa = (($urandom_range(0, 1) == 1) ? a : (32'h100 + ($urandom_range(0, 3) << 2))) | $urandom_range(0, 3);
        runTxn(1'b1, a, $urandom, $urandom_range(0, 3), sn, sa);
      end else begin
        runTxn(k == 9, a | $urandom_range(1, 3), $urandom, 0, 1'b0, 32'h0);
      end
      if ($urandom_range(0, 3) == 0) begin
        idleCycle(1'b1, (32'h100 + ($urandom_range(0, 3) << 2)) | $urandom_range(0, 3));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
